// File: rtl/iterative_mul_div_unit.sv
// iterative_mul_div_unit: HI/LO multiply/restoring-divide unit with cancel; MDU_MADD_EN enables MADD/MSUB ops 8-11
module iterative_mul_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] read_data
);
    localparam logic [3:0] OP_RD_HI = 4'd0;
    localparam logic [3:0] OP_RD_LO = 4'd1;
    localparam logic [3:0] OP_WR_HI = 4'd2;
    localparam logic [3:0] OP_WR_LO = 4'd3;
    localparam int CNT_MAX = WIDTH > MUL_LATENCY ? WIDTH : MUL_LATENCY;
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0]   hi, lo, a_q, b_q, rem;
    logic [CW-1:0]      count;
    logic               uns_q, dz, neg_q, neg_r;
    logic               is_mul, is_div, sdiv, accept, last, take, mul_fin, fix_fin;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;

`ifdef MDU_MADD_EN
    logic acc_q, sub_q;
    assign is_mul  = op == 4'd4 || op == 4'd5 || (op >= 4'd8 && op <= 4'd11);
    assign mul_res = acc_q ? (sub_q ? {hi, lo} - prod : {hi, lo} + prod) : prod;
`else
    assign is_mul  = op == 4'd4 || op == 4'd5;
    assign mul_res = prod;
`endif
    assign is_div  = op == 4'd6 || op == 4'd7;
    assign sdiv    = is_div && !op[0];
    assign accept  = state == IDLE && start && !cancel && (is_mul || is_div);
    assign last    = count == CW'(1);
    assign mul_fin = state == MUL && last && !cancel;
    assign fix_fin = state == FIX && !cancel;
    assign busy    = state != IDLE;

    assign ext_a = uns_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign ext_b = uns_q ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod  = ext_a * ext_b;

    // a_q doubles as the dividend/quotient shift register during DIV
    assign rem_sh  = {rem, a_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, b_q};
    assign take    = !rem_sub[WIDTH];

    assign read_data = op == OP_RD_HI ? hi : op == OP_RD_LO ? lo : '0;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cancel && state != IDLE) state_next = IDLE;
        else begin
            unique case (state)
                IDLE: if (accept) state_next = is_div ? DIV : MUL;
                MUL:  if (last) state_next = IDLE;
                DIV:  if (last) state_next = FIX;
                FIX:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            count       <= '0;
        end else begin
            done <= mul_fin || fix_fin;
            if (accept) begin
                uns_q       <= op[0];
`ifdef MDU_MADD_EN
                acc_q       <= op[3];
                sub_q       <= op[1];
`endif
                count       <= is_div ? CW'(WIDTH) : CW'(MUL_LATENCY);
                div_by_zero <= 1'b0;
                rem         <= '0;
                dz          <= operand_b == '0;
                neg_q       <= sdiv && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                neg_r       <= sdiv && operand_a[WIDTH-1];
                a_q         <= sdiv && operand_a[WIDTH-1] ? -operand_a : operand_a;
                b_q         <= sdiv && operand_b[WIDTH-1] ? -operand_b : operand_b;
            end else if (state == DIV) begin
                count <= count - CW'(1);
                rem   <= take ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                a_q   <= {a_q[WIDTH-2:0], take};
            end else if (state == MUL) count <= count - CW'(1);
            if (mul_fin) {hi, lo} <= mul_res;
            if (fix_fin) begin
                if (dz) div_by_zero <= 1'b1;
                else begin
                    lo <= neg_q ? -a_q : a_q;
                    hi <= neg_r ? -rem : rem;
                end
            end
            if (state == IDLE && op == OP_WR_HI) hi <= operand_a;
            if (state == IDLE && op == OP_WR_LO) lo <= operand_a;
        end
    end
endmodule

// File: tb/tb_iterative_mul_div_unit.sv
// tb_iterative_mul_div_unit: directed and randomized checks against a plain-arithmetic HI/LO model
module tb_iterative_mul_div_unit;
    localparam logic [3:0] NOP = 4'hF;
    logic        clock = 0, reset = 1, start = 0, cancel = 0;
    logic [3:0]  op = NOP;
    logic [31:0] operand_a = 0, operand_b = 0;
    logic        busy, done, div_by_zero;
    logic [31:0] read_data;
    int          checks = 0, failures = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic        m_dbz = 0;

    iterative_mul_div_unit #(.WIDTH(32), .MUL_LATENCY(5)) dut (
        .clock(clock), .reset(reset), .op(op), .start(start), .cancel(cancel),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .read_data(read_data)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
        op = 4'd0;
        #1 h = read_data;
        op = 4'd1;
        #1 l = read_data;
        op = NOP;
    endtask

    task automatic wr(input logic [3:0] o, input logic [31:0] d);
        op = o;
        operand_a = d;
        tick();
        op = NOP;
        if (o == 4'd2) m_hi = d;
        else m_lo = d;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic got_done);
        op = o;
        start = 1;
        operand_a = a;
        operand_b = b;
        tick();
        start = 0;
        op = NOP;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        got_done = done;
    endtask

    function automatic logic [63:0] ref_mul(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
        longint p;
        if (o[0]) p = longint'({32'b0, a}) * longint'({32'b0, b});
        else p = longint'($signed(a)) * longint'($signed(b));
        if (o == 4'd8 || o == 4'd9) return acc + 64'(p);
        if (o == 4'd10 || o == 4'd11) return acc - 64'(p);
        return 64'(p);
    endfunction

    function automatic logic [63:0] ref_div(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        if (o[0]) return {a % b, a / b};
        sa = int'(a);
        sb = int'(b);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o == 4'd6 || o == 4'd7) begin
            m_dbz = b == 0;
            if (b != 0) {m_hi, m_lo} = ref_div(o, a, b);
        end else begin
            m_dbz = 0;
            {m_hi, m_lo} = ref_mul(o, a, b, {m_hi, m_lo});
        end
    endtask

    task automatic test_reset;
        logic [31:0] h, l;
        read_hl(h, l);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        checks++; if (h !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", h); end
        checks++; if (l !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", l); end
    endtask

    task automatic test_directed;
        logic [3:0]  ops [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd6};
        logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF};
        logic [31:0] eh  [5] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h0};
        logic [31:0] el  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h3, 32'h80000000};
        int          el_cyc, cyc;
        logic        gd;
        logic [31:0] h, l;
        for (int i = 0; i < 5; i++) begin
            el_cyc = ops[i] >= 4'd6 ? 33 : 5;
            issue(ops[i], as[i], bs[i], cyc, gd);
            model_apply(ops[i], as[i], bs[i]);
            read_hl(h, l);
            checks++; if (cyc != el_cyc) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, cyc, el_cyc); end
            checks++; if (gd !== 1'b1) begin failures++; $display("FAIL dir%0d_done got=%b exp=1", i, gd); end
            checks++; if (h !== eh[i]) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, h, eh[i]); end
            checks++; if (l !== el[i]) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, l, el[i]); end
            tick();
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_div_by_zero;
        int          cyc;
        logic        gd;
        logic [31:0] h, l;
        wr(4'd2, 32'h11);
        wr(4'd3, 32'h22);
        issue(4'd6, 32'd5, 32'd0, cyc, gd);
        read_hl(h, l);
        checks++; if (cyc != 33) begin failures++; $display("FAIL dz_latency got=%0d exp=33", cyc); end
        checks++; if (gd !== 1'b1) begin failures++; $display("FAIL dz_done got=%b exp=1", gd); end
        checks++; if (h !== 32'h11 || l !== 32'h22) begin failures++; $display("FAIL dz_hilo got=%h:%h exp=11:22", h, l); end
        checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
        tick();
        checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_sticky got=%b exp=1", div_by_zero); end
        issue(4'd4, 32'd1, 32'd1, cyc, gd);
        model_apply(4'd4, 32'd1, 32'd1);
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dz_clear got=%b exp=0", div_by_zero); end
    endtask

    task automatic test_cancel;
        int          ndone;
        logic [31:0] h, l;
        wr(4'd2, 32'hA);
        wr(4'd3, 32'hB);
        op = 4'd6; start = 1; operand_a = 32'd1000; operand_b = 32'd3;
        tick();
        start = 0; op = NOP;
        m_dbz = 0;
        repeat (9) tick();
        wr(4'd3, 32'h55);
        m_lo = 32'hB;
        op = 4'd5; start = 1; operand_a = 32'd9; operand_b = 32'd9;
        tick();
        start = 0; op = NOP;
        read_hl(h, l);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cancel_busy_before got=%b exp=1", busy); end
        checks++; if (h !== 32'hA || l !== 32'hB) begin failures++; $display("FAIL busy_read got=%h:%h exp=a:b", h, l); end
        cancel = 1;
        tick();
        cancel = 0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", busy); end
        ndone = 0;
        repeat (40) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL cancel_done got=%0d exp=0", ndone); end
        read_hl(h, l);
        checks++; if (h !== 32'hA || l !== 32'hB) begin failures++; $display("FAIL cancel_hilo got=%h:%h exp=a:b", h, l); end
        op = 4'd4; start = 1; operand_a = 32'd3; operand_b = 32'd3;
        tick();
        start = 0; op = NOP;
        repeat (4) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL last_cycle_busy got=%b exp=1", busy); end
        cancel = 1;
        tick();
        cancel = 0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL last_cancel got=busy%b,done%b exp=0,0", busy, done); end
        read_hl(h, l);
        checks++; if (h !== 32'hA || l !== 32'hB) begin failures++; $display("FAIL last_cancel_hilo got=%h:%h exp=a:b", h, l); end
        op = 4'd4; start = 1; cancel = 1;
        tick();
        start = 0; cancel = 0; op = NOP;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_cancel_busy got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL idle_cancel_done got=%b exp=0", done); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] h, l;
        op = 4'd5; start = 1; operand_a = 32'd7; operand_b = 32'd7;
        tick();
        start = 0; op = NOP;
        tick();
        reset = 1;
        tick();
        reset = 0;
        m_hi = 0; m_lo = 0; m_dbz = 0;
        read_hl(h, l);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (h !== 32'h0 || l !== 32'h0) begin failures++; $display("FAIL rstmid_hilo got=%h:%h exp=0:0", h, l); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back;
        int          cyc;
        logic        gd;
        logic [31:0] h, l;
        issue(4'd4, 32'd6, 32'd7, cyc, gd);
        model_apply(4'd4, 32'd6, 32'd7);
        issue(4'd5, 32'h12345678, 32'h9ABCDEF0, cyc, gd);
        model_apply(4'd5, 32'h12345678, 32'h9ABCDEF0);
        read_hl(h, l);
        checks++; if (cyc != 5 || gd !== 1'b1) begin failures++; $display("FAIL b2b_timing got=%0d,%b exp=5,1", cyc, gd); end
        checks++; if (h !== m_hi || l !== m_lo) begin failures++; $display("FAIL b2b_hilo got=%h:%h exp=%h:%h", h, l, m_hi, m_lo); end
        issue(4'd4, 32'd2, 32'd3, cyc, gd);
        model_apply(4'd4, 32'd2, 32'd3);
        wr(4'd2, 32'h77);
        read_hl(h, l);
        checks++; if (h !== 32'h77 || l !== 32'd6) begin failures++; $display("FAIL done_write got=%h:%h exp=77:6", h, l); end
    endtask

    task automatic test_madd;
        int          cyc;
        logic        gd;
        logic [31:0] h, l;
`ifdef MDU_MADD_EN
        wr(4'd2, 32'd0);
        wr(4'd3, 32'd1);
        issue(4'd8, 32'd3, 32'd4, cyc, gd);
        read_hl(h, l);
        checks++; if (cyc != 5 || h !== 32'd0 || l !== 32'd13) begin failures++; $display("FAIL madd got=%0d,%h:%h exp=5,0:d", cyc, h, l); end
        wr(4'd2, 32'd0);
        wr(4'd3, 32'd0);
        issue(4'd10, 32'd1, 32'd1, cyc, gd);
        read_hl(h, l);
        m_hi = h; m_lo = l; m_dbz = 0;
        checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFF) begin failures++; $display("FAIL msub got=%h:%h exp=ffffffff:ffffffff", h, l); end
`else
        op = 4'd8; start = 1; operand_a = 32'd3; operand_b = 32'd4;
        tick();
        start = 0; op = NOP;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nomadd_busy got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL nomadd_done got=%b exp=0", done); end
        read_hl(h, l);
        checks++; if (h !== m_hi || l !== m_lo) begin failures++; $display("FAIL nomadd_hilo got=%h:%h exp=%h:%h", h, l, m_hi, m_lo); end
        cyc = 0; gd = 0;
`endif
    endtask

    task automatic test_random;
        logic [3:0]  o;
        logic [31:0] a, b, h, l;
        int          cyc, el_cyc, n;
        logic        gd;
`ifdef MDU_MADD_EN
        n = 8;
`else
        n = 4;
`endif
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) wr($urandom_range(0, 1) ? 4'd2 : 4'd3, $urandom);
            o = 4'(4 + $urandom_range(0, n - 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFFFFFF;
                default: ;
            endcase
            el_cyc = (o == 4'd6 || o == 4'd7) ? 33 : 5;
            issue(o, a, b, cyc, gd);
            model_apply(o, a, b);
            read_hl(h, l);
            checks++; if (cyc != el_cyc || gd !== 1'b1) begin failures++; $display("FAIL rnd%0d_timing op=%0d got=%0d,%b exp=%0d,1", i, o, cyc, gd, el_cyc); end
            checks++; if (h !== m_hi) begin failures++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, h, m_hi); end
            checks++; if (l !== m_lo) begin failures++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, l, m_lo); end
            checks++; if (div_by_zero !== m_dbz) begin failures++; $display("FAIL rnd%0d_dbz got=%b exp=%b", i, div_by_zero, m_dbz); end
            if ($urandom_range(0, 1)) tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        reset = 0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_madd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
